// File: rtl/mux_16_1_11b.sv
// mux_16_1_11b: registered 16:1 selector of 11-bit data, index S = {sel3,sel2,sel1,sel0}.
// Latency: 1 clk from any select or data change to RES (and RES_PAR when enabled).
// Backpressure: none; no handshake or enable, the selected input is sampled on every rising edge.
// Optional feature: define MUX_16_1_11B_PARITY_EN to add RES_PAR, the even parity of RES.
module mux_16_1_11b #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] L,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] O,
  input  logic [WIDTH-1:0] P,
  input  logic             sel3,
  input  logic             sel2,
  input  logic             sel1,
  input  logic             sel0,
`ifdef MUX_16_1_11B_PARITY_EN
  output logic             RES_PAR,
`endif
  output logic [WIDTH-1:0] RES
);

  // sel3 is the MSB of the index, sel0 the LSB
  logic [3:0]       sel;
  logic [WIDTH-1:0] sel_dat;

  assign sel = {sel3, sel2, sel1, sel0};

  // Full-width selection; every one of the 16 codes maps to an input, no fallback code exists
  always_comb begin
    sel_dat = A;
    unique case (sel)
      4'd0:  sel_dat = A;
      4'd1:  sel_dat = B;
      4'd2:  sel_dat = C;
      4'd3:  sel_dat = D;
      4'd4:  sel_dat = E;
      4'd5:  sel_dat = F;
      4'd6:  sel_dat = G;
      4'd7:  sel_dat = H;
      4'd8:  sel_dat = I;
      4'd9:  sel_dat = J;
      4'd10: sel_dat = K;
      4'd11: sel_dat = L;
      4'd12: sel_dat = M;
      4'd13: sel_dat = N;
      4'd14: sel_dat = O;
      4'd15: sel_dat = P;
      default: sel_dat = A;
    endcase
  end

  // Output register: reset clears it immediately, otherwise it loads the selected input every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RES <= '0;
    end else begin
      RES <= sel_dat;
    end
  end

`ifdef MUX_16_1_11B_PARITY_EN
  // Parity register tracks the same value that RES loads, so both move on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RES_PAR <= 1'b0;
    end else begin
      RES_PAR <= ^sel_dat;
    end
  end
`endif

endmodule

// File: tb/tb_mux_16_1_11b.sv
module tb_mux_16_1_11b;

  logic        clk;
  logic        rst_n;
  logic [10:0] din [16];
  logic [3:0]  sel;
  logic [10:0] res;
`ifdef MUX_16_1_11B_PARITY_EN
  logic        res_par;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed sweep vectors for A..P
  logic [10:0] sweep_tab [16] = '{
    11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020, 11'h040, 11'h080,
    11'h100, 11'h200, 11'h400, 11'h7FE, 11'h7FD, 11'h7FB, 11'h7F7, 11'h7EF
  };

  mux_16_1_11b #(.WIDTH(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (din[0]),
    .B     (din[1]),
    .C     (din[2]),
    .D     (din[3]),
    .E     (din[4]),
    .F     (din[5]),
    .G     (din[6]),
    .H     (din[7]),
    .I     (din[8]),
    .J     (din[9]),
    .K     (din[10]),
    .L     (din[11]),
    .M     (din[12]),
    .N     (din[13]),
    .O     (din[14]),
    .P     (din[15]),
    .sel3  (sel[3]),
    .sel2  (sel[2]),
    .sel1  (sel[1]),
    .sel0  (sel[0]),
`ifdef MUX_16_1_11B_PARITY_EN
    .RES_PAR (res_par),
`endif
    .RES   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_sweep();
    for (int i = 0; i < 16; i++) din[i] = sweep_tab[i];
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with arbitrary inputs
    rst_n = 1'b0;
    sel   = 4'd7;
    for (int i = 0; i < 16; i++) din[i] = 11'h5A5 ^ 11'(i * 37);
    #1;
    check("reset_now", res, 11'h000);
`ifdef MUX_16_1_11B_PARITY_EN
    check("reset_par", {10'd0, res_par}, 11'h000);
`endif
    edge_sample();
    check("reset_edge", res, 11'h000);

    // Release reset and sweep all 16 codes, two edges each
    @(negedge clk);
    rst_n = 1'b1;
    load_sweep();
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      sel = 4'(s);
      edge_sample();
      check($sformatf("sweep_s%0d", s), res, sweep_tab[s]);
      edge_sample();
      check($sformatf("hold_s%0d", s), res, sweep_tab[s]);
    end

    // Latency: 0 -> 15 shows no change until the next rising edge
    @(negedge clk);
    sel = 4'd0;
    edge_sample();
    check("lat_s0", res, 11'h001);
`ifdef MUX_16_1_11B_PARITY_EN
    check("par_001", {10'd0, res_par}, 11'h001);
`endif
    @(negedge clk);
    sel = 4'd15;
    #1;
    check("lat_before_edge", res, 11'h001);
    edge_sample();
    check("lat_after_edge", res, 11'h7EF);

    // Isolation: S=5, toggle every input except F
    @(negedge clk);
    sel = 4'd5;
    edge_sample();
    check("iso_start", res, 11'h020);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) if (i != 5) din[i] = ~din[i];
      edge_sample();
      check($sformatf("iso_%0d", k), res, 11'h020);
    end

    // Simultaneous select and data change
    @(negedge clk);
    sel = 4'd3;
    din[3] = 11'h555;
    edge_sample();
    check("sel_and_data", res, 11'h555);
    @(negedge clk);
    sel = 4'd9;
    din[9] = 11'h2AA;
    din[3] = 11'h000;
    edge_sample();
    check("sel_and_data2", res, 11'h2AA);

    // Mid-run reset: pending S=11 load discarded, first edge after release loads L
    @(negedge clk);
    load_sweep();
    sel = 4'd0;
    edge_sample();
    check("pre_rst", res, 11'h001);
    #2;
    sel = 4'd11;
    rst_n = 1'b0;
    #1;
    check("midrst_now", res, 11'h000);
`ifdef MUX_16_1_11B_PARITY_EN
    check("midrst_par", {10'd0, res_par}, 11'h000);
`endif
    edge_sample();
    check("midrst_edge", res, 11'h000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_released", res, 11'h000);
    edge_sample();
    check("post_rst", res, 11'h7FE);
`ifdef MUX_16_1_11B_PARITY_EN
    check("par_7fe", {10'd0, res_par}, 11'h000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
